// File: rtl/tpu_package.sv
// Shared types for the unified buffer read path: read-walk mode and sequencer states.
package tpu_package;

  typedef enum logic {
    UB_RD_OUTER  = 1'b0,
    UB_RD_LINEAR = 1'b1
  } ub_rd_mode_e;

  typedef enum logic [1:0] {
    UB_IDLE = 2'd0,
    UB_READ = 2'd1,
    UB_DONE = 2'd2
  } ub_rd_state_e;

endpackage

// File: rtl/ub_wrap_counter.sv
// Up-counter 0..max_i that wraps to zero; wrap_o flags the enabled step that leaves max_i.
module ub_wrap_counter #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         en_i,
  input  logic         clr_i,
  input  logic [W-1:0] max_i,
  output logic [W-1:0] cnt_o,
  output logic         wrap_o
);

  logic [W-1:0] cnt_q;

  assign wrap_o = en_i & (cnt_q == max_i);
  assign cnt_o  = cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i) begin
      cnt_q <= wrap_o ? '0 : cnt_q + W'(1);
    end
  end

endmodule

// File: rtl/unified_buffer_read_sequencer.sv
// Read-address sequencer for the unified buffer: walks tiled operands (OUTER or LINEAR)
// toward the systolic array with start/busy/done handshake, back-pressure and abort.
//   state   | meaning
//   UB_IDLE | waiting for start_i, config registers hold last run
//   UB_READ | issuing one word per cycle while rd_ready_i is high
//   UB_DONE | one cycle, done_o high, then back to idle
module unified_buffer_read_sequencer
  import tpu_package::*;
#(
  parameter int ADDR_W = 12,
  parameter int DIM_W  = 8,
  parameter int TILE_W = 3
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic              abort_i,
  input  ub_rd_mode_e       mode_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  input  logic [DIM_W-1:0]  v_dim_i,
  input  logic [DIM_W-1:0]  v_dim1_i,
  input  logic [TILE_W-1:0] y_tiles1_i,
  input  logic [TILE_W-1:0] x_tiles1_i,
  input  logic              rd_ready_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              rd_en_o,
  output logic [ADDR_W-1:0] rd_addr_o,
  output logic [TILE_W-1:0] tile_x_o,
  output logic [TILE_W-1:0] tile_y_o,
  output logic              last_word_o
);

  ub_rd_state_e      state_q;
  ub_rd_mode_e       mode_q;
  logic              busy_q, done_q;
  logic [DIM_W-1:0]  v_dim_q, v_dim1_q;
  logic [TILE_W-1:0] y_tiles1_q, x_tiles1_q;
  logic [ADDR_W-1:0] row_base_q, row_base_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [ADDR_W-1:0] v_dim_ext;

  logic              rd_en, start_acc, abort_acc, cnt_clr;
  logic              word_wrap, y_en, y_wrap, x_en, x_wrap;
  logic [DIM_W-1:0]  word_cnt;

  assign rd_en     = (state_q == UB_READ) & rd_ready_i;
  assign start_acc = (state_q == UB_IDLE) & start_i;
  assign abort_acc = (state_q == UB_READ) & abort_i;
  assign cnt_clr   = start_acc | abort_acc;
  assign v_dim_ext = ADDR_W'(v_dim_q);

  // y only steps in OUTER; x steps at every tile end in LINEAR, after the last y pass in OUTER
  assign y_en = word_wrap & (mode_q == UB_RD_OUTER);
  assign x_en = word_wrap & ((mode_q == UB_RD_LINEAR) | y_wrap);

  ub_wrap_counter #(.W(DIM_W)) u_word_cnt (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .en_i   (rd_en),
    .clr_i  (cnt_clr),
    .max_i  (v_dim1_q),
    .cnt_o  (word_cnt),
    .wrap_o (word_wrap)
  );

  ub_wrap_counter #(.W(TILE_W)) u_y_cnt (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .en_i   (y_en),
    .clr_i  (cnt_clr),
    .max_i  (y_tiles1_q),
    .cnt_o  (tile_y_o),
    .wrap_o (y_wrap)
  );

  ub_wrap_counter #(.W(TILE_W)) u_x_cnt (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .en_i   (x_en),
    .clr_i  (cnt_clr),
    .max_i  (x_tiles1_q),
    .cnt_o  (tile_x_o),
    .wrap_o (x_wrap)
  );

  always_comb begin
    row_base_d = row_base_q;
    rd_addr_d  = rd_addr_q;
    if (start_acc) begin
      row_base_d = base_addr_i;
      rd_addr_d  = base_addr_i;
    end else if (rd_en) begin
      if (!word_wrap) begin
        rd_addr_d = rd_addr_q + ADDR_W'(1);
      end else if (!x_en) begin
        rd_addr_d = row_base_q;
      end else begin
        row_base_d = row_base_q + v_dim_ext;
        rd_addr_d  = row_base_q + v_dim_ext;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= UB_IDLE;
      mode_q     <= UB_RD_OUTER;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      v_dim_q    <= '0;
      v_dim1_q   <= '0;
      y_tiles1_q <= '0;
      x_tiles1_q <= '0;
      row_base_q <= '0;
      rd_addr_q  <= '0;
    end else begin
      row_base_q <= row_base_d;
      rd_addr_q  <= rd_addr_d;
      unique case (state_q)
        UB_IDLE: begin
          done_q <= 1'b0;
          if (start_i) begin
            state_q    <= UB_READ;
            busy_q     <= 1'b1;
            mode_q     <= mode_i;
            v_dim_q    <= v_dim_i;
            v_dim1_q   <= v_dim1_i;
            y_tiles1_q <= y_tiles1_i;
            x_tiles1_q <= x_tiles1_i;
          end
        end
        UB_READ: begin
          // abort beats a coincident final word: the word still goes out, done does not
          if (abort_i) begin
            state_q <= UB_IDLE;
            busy_q  <= 1'b0;
          end else if (x_wrap) begin
            state_q <= UB_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        UB_DONE: begin
          state_q <= UB_IDLE;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= UB_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign rd_en_o     = rd_en;
  assign rd_addr_o   = rd_addr_q;
  assign last_word_o = (state_q == UB_READ) & (word_cnt == v_dim1_q);

endmodule
